// File: rtl/mem_host_if.sv
// Host-side request/response front end for an SRAM macro controller: single-beat reads/writes plus BIST sequencing.
// Optional feature: define MEM_HOST_IF_RSP_PARITY_EN to add RSP_PAR (odd parity of captured read data).
module mem_host_if #(
    parameter int unsigned RD_LAT   = 2,
    parameter logic [19:0] BIST_LEN = 20'd262144
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [7:0]  RSP_RDATA,
    input  logic        BIST_START,
    input  logic [2:0]  BIST_MODE_IN,
    output logic        BIST_DONE,
    output logic        BIST_RESULT,
    output logic [15:0] ADDR,
    output logic        CE,
    output logic        CSB,
    output logic        WEB,
    output logic        OEB,
    output logic [7:0]  IDATA,
    output logic        BIST_EN,
    output logic [2:0]  BIST_MODE,
    input  logic [7:0]  ODATA,
    input  logic        BIST_PASS
`ifdef MEM_HOST_IF_RSP_PARITY_EN
    ,
    output logic        RSP_PAR
`endif
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 20;
    localparam int unsigned MW = 3;

    localparam logic [CW-1:0] RWAIT_LAST = (RD_LAT > 1) ? CW'(RD_LAT - 2) : '0;
    localparam logic [CW-1:0] BIST_LAST  = BIST_LEN - CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RWAIT,
        ST_RESP,
        ST_BIST
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            result_q, result_d;
    logic            done_q, done_d;
    logic            rdy_q, rdy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [AW-1:0]   pin_addr_q, pin_addr_d;
    logic            ce_q, ce_d;
    logic            csb_q, csb_d;
    logic            web_q, web_d;
    logic            oeb_q, oeb_d;
    logic [DW-1:0]   idata_q, idata_d;
    logic            bist_en_q, bist_en_d;
    logic [MW-1:0]   bist_mode_q, bist_mode_d;
    logic            capture;
`ifdef MEM_HOST_IF_RSP_PARITY_EN
    logic            par_q, par_d;
`endif

    // Next-state, request latching and registered pin/handshake values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mode_d      = mode_q;
        rdata_d     = rdata_q;
        result_d    = result_q;
        done_d      = 1'b0;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BIST_START) begin
                    mode_d  = BIST_MODE_IN;
                    cnt_d   = '0;
                    state_d = ST_BIST;
                end else if (REQ_VALID) begin
                    wr_d    = REQ_WR;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else if (RD_LAT <= 1) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (cnt_q == RWAIT_LAST) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (RSP_READY) state_d = ST_IDLE;
            end
            ST_BIST: begin
                if (cnt_q == BIST_LAST) begin
                    result_d = BIST_PASS;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) rdata_d = ODATA;

        pin_addr_d  = '0;
        ce_d        = 1'b0;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        oeb_d       = 1'b1;
        idata_d     = '0;
        bist_en_d   = 1'b0;
        bist_mode_d = '0;
        // Pins are a function of the state being entered so they line up with it
        case (state_d)
            ST_ACCESS: begin
                ce_d       = 1'b1;
                csb_d      = 1'b0;
                pin_addr_d = addr_d;
                idata_d    = wr_d ? wdata_d : '0;
                web_d      = ~wr_d;
                oeb_d      = wr_d;
            end
            ST_RWAIT: begin
                csb_d      = 1'b0;
                oeb_d      = 1'b0;
                pin_addr_d = addr_d;
            end
            ST_BIST: begin
                bist_en_d   = 1'b1;
                bist_mode_d = mode_d;
            end
            default: ;
        endcase

        rdy_d       = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
`ifdef MEM_HOST_IF_RSP_PARITY_EN
        par_d = capture ? ~(^ODATA) : par_q;
`endif
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mode_q      <= '0;
            rdata_q     <= '0;
            result_q    <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            pin_addr_q  <= '0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            idata_q     <= '0;
            bist_en_q   <= 1'b0;
            bist_mode_q <= '0;
`ifdef MEM_HOST_IF_RSP_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mode_q      <= mode_d;
            rdata_q     <= rdata_d;
            result_q    <= result_d;
            done_q      <= done_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            pin_addr_q  <= pin_addr_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            idata_q     <= idata_d;
            bist_en_q   <= bist_en_d;
            bist_mode_q <= bist_mode_d;
`ifdef MEM_HOST_IF_RSP_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // A same-cycle BIST_START must veto the handshake, so ready is masked after the flop
    assign REQ_READY   = rdy_q & ~BIST_START;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rdata_q;
    assign BIST_DONE   = done_q;
    assign BIST_RESULT = result_q;
    assign ADDR        = pin_addr_q;
    assign CE          = ce_q;
    assign CSB         = csb_q;
    assign WEB         = web_q;
    assign OEB         = oeb_q;
    assign IDATA       = idata_q;
    assign BIST_EN     = bist_en_q;
    assign BIST_MODE   = bist_mode_q;
`ifdef MEM_HOST_IF_RSP_PARITY_EN
    assign RSP_PAR     = par_q;
`endif

endmodule

// File: tb/tb_mem_host_if.sv
// Directed bench for mem_host_if (RD_LAT=2, BIST_LEN=8) with a small behavioural SRAM on the pins.
`timescale 1ns/1ps
module tb_mem_host_if;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WR = 1'b0;
    logic [15:0] REQ_ADDR = 16'h0;
    logic [7:0]  REQ_WDATA = 8'h0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [7:0]  RSP_RDATA;
    logic        BIST_START = 1'b0;
    logic [2:0]  BIST_MODE_IN = 3'b0;
    logic        BIST_DONE;
    logic        BIST_RESULT;
    logic [15:0] ADDR;
    logic        CE, CSB, WEB, OEB;
    logic [7:0]  IDATA;
    logic        BIST_EN;
    logic [2:0]  BIST_MODE;
    logic [7:0]  ODATA;
    logic        BIST_PASS = 1'b0;
`ifdef MEM_HOST_IF_RSP_PARITY_EN
    logic        RSP_PAR;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_host_if #(.RD_LAT(2), .BIST_LEN(20'd8)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .BIST_START(BIST_START), .BIST_MODE_IN(BIST_MODE_IN),
        .BIST_DONE(BIST_DONE), .BIST_RESULT(BIST_RESULT),
        .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB), .IDATA(IDATA),
        .BIST_EN(BIST_EN), .BIST_MODE(BIST_MODE),
        .ODATA(ODATA), .BIST_PASS(BIST_PASS)
`ifdef MEM_HOST_IF_RSP_PARITY_EN
        , .RSP_PAR(RSP_PAR)
`endif
    );

    // Behavioural SRAM: unwritten locations read as (low address byte ^ 0x3C); data only driven in the wait phase
    logic [7:0] mem   [0:255];
    logic       wflag [0:255];
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < 256; i++) wflag[i] <= 1'b0;
        end else if (CE && !CSB && !WEB) begin
            mem[ADDR[7:0]]   <= IDATA;
            wflag[ADDR[7:0]] <= 1'b1;
        end
    end
    always_comb begin
        ODATA = 8'h00;
        if (!CSB && !OEB && !CE)
            ODATA = wflag[ADDR[7:0]] ? mem[ADDR[7:0]] : (ADDR[7:0] ^ 8'h3C);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ce"},   32'(CE), 32'd0);
        check({tag, "_csb"},  32'(CSB), 32'd1);
        check({tag, "_web"},  32'(WEB), 32'd1);
        check({tag, "_oeb"},  32'(OEB), 32'd1);
        check({tag, "_addr"}, 32'(ADDR), 32'd0);
        check({tag, "_idata"}, 32'(IDATA), 32'd0);
        check({tag, "_bist_en"}, 32'(BIST_EN), 32'd0);
        check({tag, "_bist_mode"}, 32'(BIST_MODE), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_par;
        int          stall;
    } vec_t;

    task automatic wait_ready();
        int guard = 0;
        while (!REQ_READY && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        check("req_ready_wait", 32'(REQ_READY), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        wait_ready();
        REQ_VALID = 1'b1; REQ_WR = v.wr; REQ_ADDR = v.addr; REQ_WDATA = v.wdata;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check({t, "_acc_ce"},    32'(CE), 32'd1);
        check({t, "_acc_csb"},   32'(CSB), 32'd0);
        check({t, "_acc_web"},   32'(WEB), 32'(!v.wr));
        check({t, "_acc_oeb"},   32'(OEB), 32'(v.wr));
        check({t, "_acc_addr"},  32'(ADDR), 32'(v.addr));
        check({t, "_acc_idata"}, 32'(IDATA), v.wr ? 32'(v.wdata) : 32'd0);
        check({t, "_acc_ready"}, 32'(REQ_READY), 32'd0);
        if (v.wr) begin
            @(negedge CLK);
            check({t, "_wr_ready"}, 32'(REQ_READY), 32'd1);
            check({t, "_wr_norsp"}, 32'(RSP_VALID), 32'd0);
            check({t, "_wr_ce"},    32'(CE), 32'd0);
        end else begin
            @(negedge CLK);
            check({t, "_rw_ce"},   32'(CE), 32'd0);
            check({t, "_rw_csb"},  32'(CSB), 32'd0);
            check({t, "_rw_oeb"},  32'(OEB), 32'd0);
            check({t, "_rw_addr"}, 32'(ADDR), 32'(v.addr));
            check({t, "_rw_valid"}, 32'(RSP_VALID), 32'd0);
            @(negedge CLK);
            check({t, "_rsp_valid"}, 32'(RSP_VALID), 32'd1);
            check({t, "_rsp_rdata"}, 32'(RSP_RDATA), 32'(v.exp_rdata));
            check({t, "_rsp_csb"},   32'(CSB), 32'd1);
`ifdef MEM_HOST_IF_RSP_PARITY_EN
            check({t, "_rsp_par"}, 32'(RSP_PAR), 32'(v.exp_par));
`endif
            for (int s = 0; s < v.stall; s++) begin
                @(negedge CLK);
                check({t, "_stall_valid"}, 32'(RSP_VALID), 32'd1);
                check({t, "_stall_rdata"}, 32'(RSP_RDATA), 32'(v.exp_rdata));
                check({t, "_stall_ready"}, 32'(REQ_READY), 32'd0);
            end
            RSP_READY = 1'b1;
            @(negedge CLK);
            RSP_READY = 1'b0;
            check({t, "_rel_valid"}, 32'(RSP_VALID), 32'd0);
            check({t, "_rel_ready"}, 32'(REQ_READY), 32'd1);
        end
    endtask

    task automatic run_bist(input logic [2:0] mode, input logic pass, input int exp_len, input string t);
        int cnt = 0;
        int guard = 0;
        BIST_START = 1'b1; BIST_MODE_IN = mode; BIST_PASS = pass;
        #1;
        check({t, "_ready_masked"}, 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        BIST_START = 1'b0;
        while (BIST_EN && guard < 40) begin
            cnt++;
            check({t, "_mode"}, 32'(BIST_MODE), 32'(mode));
            check({t, "_busy_ready"}, 32'(REQ_READY), 32'd0);
            @(negedge CLK);
            guard++;
        end
        check({t, "_en_len"}, 32'(cnt), 32'(exp_len));
        check({t, "_done"}, 32'(BIST_DONE), 32'd1);
        check({t, "_result"}, 32'(BIST_RESULT), 32'(pass));
        check({t, "_end_mode"}, 32'(BIST_MODE), 32'd0);
        check({t, "_end_ready"}, 32'(REQ_READY), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 0};
        vecs[2] = '{1'b1, 16'h0056, 8'h03, 8'h00, 1'b0, 0};
        vecs[3] = '{1'b0, 16'h0056, 8'h00, 8'h03, 1'b1, 0};
        vecs[4] = '{1'b1, 16'h0178, 8'h07, 8'h00, 1'b0, 0};
        vecs[5] = '{1'b0, 16'h0178, 8'h00, 8'h07, 1'b0, 0};
        vecs[6] = '{1'b0, 16'h0011, 8'h00, 8'h2D, 1'b1, 0};
        vecs[7] = '{1'b1, 16'h12FF, 8'h00, 8'h00, 1'b0, 0};
        vecs[8] = '{1'b0, 16'h12FF, 8'h00, 8'h00, 1'b1, 0};
        vecs[9] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 5};

        // Reset state
        #12;
        check_idle_pins("rst");
        check("rst_ready", 32'(REQ_READY), 32'd0);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rdata", 32'(RSP_RDATA), 32'd0);
        check("rst_done", 32'(BIST_DONE), 32'd0);
        check("rst_result", 32'(BIST_RESULT), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        check("pre_edge_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        check("post_edge_ready", 32'(REQ_READY), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // BIST wins over a simultaneous request, which is accepted right after
        REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 16'h1234; REQ_WDATA = 8'h00;
        run_bist(3'b101, 1'b1, 8, "bist1");
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("bist1_acc_ce", 32'(CE), 32'd1);
        check("bist1_acc_addr", 32'(ADDR), 32'h1234);
        check("bist1_done_pulse", 32'(BIST_DONE), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("bist1_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("bist1_rsp_rdata", 32'(RSP_RDATA), 32'hA5);
        // BIST_START while busy in RESP is ignored
        BIST_START = 1'b1;
        @(negedge CLK);
        BIST_START = 1'b0;
        check("bist_ignored_en", 32'(BIST_EN), 32'd0);
        check("bist_ignored_valid", 32'(RSP_VALID), 32'd1);
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        check("bist_ignored_idle", 32'(BIST_EN), 32'd0);
        check("result_sticky", 32'(BIST_RESULT), 32'd1);

        run_bist(3'b010, 1'b0, 8, "bist2");
        @(negedge CLK);
        check("bist2_result_hold", 32'(BIST_RESULT), 32'd0);
        check("bist2_done_low", 32'(BIST_DONE), 32'd0);

        // Asynchronous reset in the middle of a read wait
        wait_ready();
        REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 16'h0056;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("rwait_csb", 32'(CSB), 32'd0);
        #2;
        RSTN = 1'b0;
        #1;
        check_idle_pins("arst");
        check("arst_valid", 32'(RSP_VALID), 32'd0);
        check("arst_ready", 32'(REQ_READY), 32'd0);
        check("arst_result", 32'(BIST_RESULT), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("arst_no_rsp", 32'(RSP_VALID), 32'd0);
        end
        check("arst_ready_back", 32'(REQ_READY), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
